// File: rtl/clk_gen.sv
// rtl/clk_gen.sv - parameterized half-period counting clock generator
// Optional edge pulses on rise_pulse/fall_pulse when CLK_GEN_EDGE_PULSE_EN is defined.
module clk_gen #(
    parameter int unsigned HALF_PERIOD = 1,
    parameter bit          INIT_LEVEL  = 1'b0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             clk_out,
    output logic [CNT_W-1:0] period_cnt
`ifdef CLK_GEN_EDGE_PULSE_EN
    ,
    output logic             rise_pulse,
    output logic             fall_pulse
`endif
);

    if (HALF_PERIOD < 1 || HALF_PERIOD > 65535) begin : g_bad_half_period
        $error("clk_gen: HALF_PERIOD must be in 1..65535");
    end
    if (CNT_W < 32 && (HALF_PERIOD - 1) >= (32'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("clk_gen: CNT_W too narrow for HALF_PERIOD-1");
    end

    localparam logic [CNT_W-1:0] HCNT_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] r_hcnt;
    logic             r_clk_out;
    logic [CNT_W-1:0] r_period_cnt;

    logic w_terminal;
    logic w_toggle;
    logic w_rising;

    assign w_terminal = (r_hcnt == HCNT_LAST);
    assign w_toggle   = en & w_terminal;
    // A toggle from a low output is the start of a new period.
    assign w_rising   = w_toggle & ~r_clk_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
        end else if (en) begin
            if (w_terminal) begin
                r_hcnt <= '0;
            end else begin
                r_hcnt <= r_hcnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_out <= INIT_LEVEL;
        end else if (w_toggle) begin
            r_clk_out <= ~r_clk_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
        end else if (w_rising) begin
            r_period_cnt <= r_period_cnt + CNT_ONE;
        end
    end

    assign clk_out    = r_clk_out;
    assign period_cnt = r_period_cnt;

`ifdef CLK_GEN_EDGE_PULSE_EN
    logic r_rise_pulse;
    logic r_fall_pulse;

    // Pulses land in the same cycle the registered output takes its new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise_pulse <= 1'b0;
            r_fall_pulse <= 1'b0;
        end else begin
            r_rise_pulse <= w_toggle & ~r_clk_out;
            r_fall_pulse <= w_toggle &  r_clk_out;
        end
    end

    assign rise_pulse = r_rise_pulse;
    assign fall_pulse = r_fall_pulse;
`endif

endmodule

// File: tb/tb_clk_gen.sv
// tb/tb_clk_gen.sv - self-checking bench for clk_gen over four parameter sets
module tb_clk_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    localparam int NI = 4;
    int hp   [NI] = '{1, 3, 2, 1};
    bit init [NI] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int cw   [NI] = '{16, 16, 4, 2};

    int n   [NI];
    bit tog [NI];

    logic        c0, c1, c2, c3;
    logic [15:0] p0, p1;
    logic [3:0]  p2;
    logic [1:0]  p3;
    logic r0, r1, r2, r3, f0, f1, f2, f3;

    clk_gen #(.HALF_PERIOD(1), .INIT_LEVEL(1'b0), .CNT_W(16)) u_hp1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clk_out(c0), .period_cnt(p0)
`ifdef CLK_GEN_EDGE_PULSE_EN
        , .rise_pulse(r0), .fall_pulse(f0)
`endif
    );
    clk_gen #(.HALF_PERIOD(3), .INIT_LEVEL(1'b0), .CNT_W(16)) u_hp3 (
        .clk(clk), .rst_n(rst_n), .en(en), .clk_out(c1), .period_cnt(p1)
`ifdef CLK_GEN_EDGE_PULSE_EN
        , .rise_pulse(r1), .fall_pulse(f1)
`endif
    );
    clk_gen #(.HALF_PERIOD(2), .INIT_LEVEL(1'b0), .CNT_W(4)) u_hp2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clk_out(c2), .period_cnt(p2)
`ifdef CLK_GEN_EDGE_PULSE_EN
        , .rise_pulse(r2), .fall_pulse(f2)
`endif
    );
    clk_gen #(.HALF_PERIOD(1), .INIT_LEVEL(1'b1), .CNT_W(2)) u_init1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clk_out(c3), .period_cnt(p3)
`ifdef CLK_GEN_EDGE_PULSE_EN
        , .rise_pulse(r3), .fall_pulse(f3)
`endif
    );

`ifndef CLK_GEN_EDGE_PULSE_EN
    assign {r0, r1, r2, r3, f0, f1, f2, f3} = '0;
`endif

    // Output level after n enabled cycles: one toggle per completed half period.
    function automatic logic exp_clk(input int i);
        return init[i] ^ logic'((n[i] / hp[i]) % 2);
    endfunction

    // Toggle k leaves level init^(k%2); rising toggles are odd k from low, even k from high.
    function automatic logic [31:0] exp_pc(input int i);
        int t;
        int k;
        t = n[i] / hp[i];
        k = init[i] ? (t / 2) : ((t + 1) / 2);
        return 32'(k % (1 << cw[i]));
    endfunction

    task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d] n=%0d observed=%0h expected=%0h", tag, i, n[i], obs, exp);
        end
    endtask

    task automatic check_inst(input int i, input logic c, input logic [31:0] p, input logic r, input logic f);
        check("clk_out", i, {31'b0, c}, {31'b0, exp_clk(i)});
        check("period_cnt", i, p, exp_pc(i));
`ifdef CLK_GEN_EDGE_PULSE_EN
        check("rise_pulse", i, {31'b0, r}, {31'b0, tog[i] & exp_clk(i)});
        check("fall_pulse", i, {31'b0, f}, {31'b0, tog[i] & ~exp_clk(i)});
`else
        if (r | f) check("pulse_absent", i, {31'b0, r | f}, 32'd0);
`endif
    endtask

    task automatic check_all();
        check_inst(0, c0, 32'(p0), r0, f0);
        check_inst(1, c1, 32'(p1), r1, f1);
        check_inst(2, c2, 32'(p2), r2, f2);
        check_inst(3, c3, 32'(p3), r3, f3);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            n[i] = 0;
            tog[i] = 1'b0;
        end
    endtask

    // Called at a negedge; applies en for one rising edge and checks at the next negedge.
    task automatic step(input logic e);
        en = e;
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (e) begin
                n[i]++;
                tog[i] = (n[i] % hp[i] == 0);
            end else begin
                tog[i] = 1'b0;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Enable run, pause mid half-period, resume with no phase reset.
        step(1'b1);
        step(1'b1);
        repeat (5) step(1'b0);
        step(1'b1);
        check("hp3_resume_toggle", 1, {31'b0, c1}, 32'd1);
        repeat (14) step(1'b1);

        async_reset_pulse();
        repeat (10) step(1'b1);

        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            if (k == 150) async_reset_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
